// File: rtl/video_compositor_pipelined_pkg.sv
// Shared definitions for the pipelined video compositor: RGB332 expansion,
// character codes, default OSD geometry and the glyph colour.
package video_compositor_pipelined_pkg;

  localparam int DEF_OSD_X0    = 160;
  localparam int DEF_OSD_Y0    = 24;
  localparam int DEF_OSD_COLS  = 32;
  localparam int DEF_OSD_ROWS  = 24;
  localparam int DEF_CELL_W    = 10;
  localparam int DEF_CELL_H    = 18;
  localparam int DEF_DIM_SHIFT = 3;
  localparam logic [23:0] DEF_OSD_FG = 24'hD5C4A1;

  // The font ROM leaves SPC blank, which is what makes cell borders empty.
  localparam logic [4:0] C_0 = 5'h00;
  localparam logic [4:0] C_9 = 5'h09;
  localparam logic [4:0] C__ = 5'h1F;
  localparam logic [4:0] SPC = 5'h1E;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  function automatic rgb888_t expand_rgb332(input logic [7:0] p);
    rgb888_t c;
    c.r = {p[2:0], 5'b0};
    c.g = {p[5:3], 5'b0};
    c.b = {p[7:6], 6'b0};
    return c;
  endfunction

  function automatic rgb888_t dim_rgb(input rgb888_t c, input int unsigned sh);
    rgb888_t d;
    d.r = c.r >> sh;
    d.g = c.g >> sh;
    d.b = c.b >> sh;
    return d;
  endfunction

endpackage

// File: rtl/video_compositor_pipelined_osd_cell_counter.sv
// Incremental OSD cell tracker: turns the raster x/y stream into character
// row/column and the pixel position inside the cell, without any dividers.
module osd_cell_counter
  import video_compositor_pipelined_pkg::*;
#(
  parameter int X0     = DEF_OSD_X0,
  parameter int Y0     = DEF_OSD_Y0,
  parameter int COLS   = DEF_OSD_COLS,
  parameter int ROWS   = DEF_OSD_ROWS,
  parameter int CELL_W = DEF_CELL_W,
  parameter int CELL_H = DEF_CELL_H,
  parameter int CX_W   = $clog2(CELL_W),
  parameter int CY_W   = $clog2(CELL_H)
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            pixel_valid,
  input  logic [9:0]      pixel_x_pos,
  input  logic [9:0]      pixel_y_pos,
  output logic            in_osd,
  output logic [4:0]      row,
  output logic [4:0]      col,
  output logic [CX_W-1:0] cell_x,
  output logic [CY_W-1:0] cell_y
);

  localparam logic [9:0] X_FIRST = 10'(X0);
  localparam logic [9:0] X_LAST  = 10'(X0 + COLS * CELL_W - 1);
  localparam logic [9:0] Y_FIRST = 10'(Y0);
  localparam logic [9:0] Y_LAST  = 10'(Y0 + ROWS * CELL_H - 1);

  logic box_hit;
  logic line_in_box;

  assign box_hit = (pixel_x_pos >= X_FIRST) && (pixel_x_pos <= X_LAST) &&
                   (pixel_y_pos >= Y_FIRST) && (pixel_y_pos <= Y_LAST);
  assign line_in_box = (pixel_y_pos > Y_FIRST) && (pixel_y_pos <= Y_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      in_osd <= 1'b0;
      cell_x <= '0;
      col    <= '0;
    end else if (pixel_valid) begin
      in_osd <= box_hit;
      if (pixel_x_pos == X_FIRST) begin
        cell_x <= '0;
        col    <= '0;
      end else if (box_hit) begin
        if (cell_x == CX_W'(CELL_W - 1)) begin
          cell_x <= '0;
          col    <= col + 5'd1;
        end else begin
          cell_x <= cell_x + CX_W'(1);
        end
      end
    end
  end

  // Line counters only move at the first pixel of a line, so a mid-line
  // restart never disturbs them until the next line start.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cell_y <= '0;
      row    <= '0;
    end else if (pixel_valid && pixel_x_pos == '0) begin
      if (pixel_y_pos == Y_FIRST) begin
        cell_y <= '0;
        row    <= '0;
      end else if (line_in_box) begin
        if (cell_y == CY_W'(CELL_H - 1)) begin
          cell_y <= '0;
          row    <= row + 5'd1;
        end else begin
          cell_y <= cell_y + CY_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/video_compositor_pipelined.sv
// Three-stage compositor: frame buffer select latched at end of frame, then
// OSD character cell overlay on top of the expanded RGB332 background.
module video_compositor_pipelined
  import video_compositor_pipelined_pkg::*;
#(
  parameter int          NUM_FRAMES = 2,
  parameter int          FSEL_W     = 1,
  parameter int          OSD_X0     = DEF_OSD_X0,
  parameter int          OSD_Y0     = DEF_OSD_Y0,
  parameter int          OSD_COLS   = DEF_OSD_COLS,
  parameter int          OSD_ROWS   = DEF_OSD_ROWS,
  parameter int          CELL_W     = DEF_CELL_W,
  parameter int          CELL_H     = DEF_CELL_H,
  parameter int          DIM_SHIFT  = DEF_DIM_SHIFT,
  parameter logic [23:0] OSD_FG     = DEF_OSD_FG
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    pixel_valid,
  input  logic [9:0]              pixel_x_pos,
  input  logic [9:0]              pixel_y_pos,
  input  logic                    frame_end,
  input  logic [8*NUM_FRAMES-1:0] pixel_frame,
  input  logic [FSEL_W-1:0]       frame_select_memory,
  input  logic [FSEL_W-1:0]       frame_select_switch,
  input  logic                    osd_display,
  output logic [4:0]              char_row,
  output logic [4:0]              char_col,
  input  logic [4:0]              char_code,
  output logic [4:0]              font_char,
  output logic [3:0]              font_line,
  output logic [2:0]              font_column,
  input  logic                    font_pixel,
  output logic [7:0]              pixel_red,
  output logic [7:0]              pixel_green,
  output logic [7:0]              pixel_blue,
  output logic                    pixel_valid_out
);

  localparam int CX_W = $clog2(CELL_W);
  localparam int CY_W = $clog2(CELL_H);

  logic [FSEL_W-1:0] frame_idx;
  logic [FSEL_W-1:0] req;
  logic              osd_en;
  logic [7:0]        sel_pix;

  assign req     = frame_select_memory ^ frame_select_switch;
  assign sel_pix = pixel_frame[{frame_idx, 3'b000} +: 8];

  // Out-of-range requests are ignored so a bad index can never select garbage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      frame_idx <= '0;
      osd_en    <= 1'b0;
    end else if (frame_end) begin
      if (int'(req) < NUM_FRAMES) frame_idx <= req;
      osd_en <= osd_display;
    end
  end

  logic            s1_valid;
  rgb888_t         s1_rgb;
  logic            s1_in_osd;
  logic [4:0]      s1_row;
  logic [4:0]      s1_col;
  logic [CX_W-1:0] s1_cell_x;
  logic [CY_W-1:0] s1_cell_y;

  osd_cell_counter #(
    .X0(OSD_X0), .Y0(OSD_Y0), .COLS(OSD_COLS), .ROWS(OSD_ROWS),
    .CELL_W(CELL_W), .CELL_H(CELL_H)
  ) u_cell_counter (
    .clock(clock), .reset_n(reset_n), .pixel_valid(pixel_valid),
    .pixel_x_pos(pixel_x_pos), .pixel_y_pos(pixel_y_pos),
    .in_osd(s1_in_osd), .row(s1_row), .col(s1_col),
    .cell_x(s1_cell_x), .cell_y(s1_cell_y)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_rgb   <= '0;
    end else begin
      s1_valid <= pixel_valid;
      if (pixel_valid) s1_rgb <= expand_rgb332(sel_pix);
    end
  end

  assign char_row = s1_row;
  assign char_col = s1_col;

  logic       s1_border;
  logic       s2_valid;
  rgb888_t    s2_rgb;
  logic       s2_in_osd;
  logic       s2_border;
  logic [3:0] s2_line;
  logic [2:0] s2_column;

  assign s1_border = (s1_cell_x == '0) || (s1_cell_x == CX_W'(CELL_W - 1)) ||
                     (s1_cell_y == '0) || (s1_cell_y == CY_W'(CELL_H - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid  <= 1'b0;
      s2_rgb    <= '0;
      s2_in_osd <= 1'b0;
      s2_border <= 1'b0;
      s2_line   <= '0;
      s2_column <= '0;
    end else begin
      s2_valid  <= s1_valid;
      s2_rgb    <= s1_rgb;
      s2_in_osd <= s1_in_osd;
      s2_border <= s1_border;
      s2_line   <= s1_border ? 4'd0 : 4'(s1_cell_y - CY_W'(1));
      s2_column <= s1_border ? 3'd0 : 3'(s1_cell_x - CX_W'(1));
    end
  end

  // Char RAM data lines up with stage 2; bubbles present code 0 so the font
  // address is quiet (and zero through reset).
  assign font_char   = !s2_valid ? 5'd0 : (s2_border ? SPC : char_code);
  assign font_line   = s2_line;
  assign font_column = s2_column;

  rgb888_t out_rgb;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_rgb         <= '0;
      pixel_valid_out <= 1'b0;
    end else begin
      pixel_valid_out <= s2_valid;
      if (!s2_valid)                  out_rgb <= '0;
      else if (!osd_en || !s2_in_osd) out_rgb <= s2_rgb;
      else if (font_pixel)            out_rgb <= OSD_FG;
      else                            out_rgb <= dim_rgb(s2_rgb, DIM_SHIFT);
    end
  end

  assign pixel_red   = out_rgb.r;
  assign pixel_green = out_rgb.g;
  assign pixel_blue  = out_rgb.b;

endmodule
